// File: rtl/alu_iter_decrement_pkg.sv
// Shared types for the iterative decrement unit.
package alu_pkg;
  localparam int ALU_W_DEFAULT = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} alu_iter_state_t;
endpackage

// File: rtl/alu_iter_decrement_if.sv
// Operand/result handshake bundle between operand select, the decrement unit and the result mux.
interface alu_iter_decrement_if import alu_pkg::*; #(
  parameter int W = ALU_W_DEFAULT
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_n;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_s;
  logic         out_borrow;
  logic         busy;

  modport slave (
    input  in_valid, in_a, in_n, abort, out_ready,
    output in_ready, out_valid, out_s, out_borrow, busy
  );

  modport master (
    output in_valid, in_a, in_n, abort, out_ready,
    input  in_ready, out_valid, out_s, out_borrow, busy
  );
endinterface

// File: rtl/alu_iter_decrement_dec_step.sv
// Combinational single-step decrementer, shared by ALU decrement users.
module alu_dec_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] d,
  output logic         bout
);
  assign d    = a - W'(1);
  assign bout = (a == '0);
endmodule

// File: rtl/alu_iter_decrement.sv
// Iterative decrement: subtracts one from the operand per clock, N times, with sticky borrow.
module alu_iter_decrement import alu_pkg::*; #(
  parameter int W        = ALU_W_DEFAULT,
  parameter bit SATURATE = 1'b0
) (
  input logic                clk,
  input logic                rst_n,
  alu_iter_decrement_if.slave io
);
  localparam logic [W-1:0] ONE = W'(1);

  alu_iter_state_t state, nstate;
  logic [W-1:0]    acc, cnt, dec, step_val;
  logic            borrow, at_zero;
  logic            load, run, clr;

  alu_dec_step #(.W(W)) u_step (
    .a    (acc),
    .d    (dec),
    .bout (at_zero)
  );

  // A wrapping step from zero already yields all-ones; only saturation needs a mux.
  assign step_val = (SATURATE && at_zero) ? '0 : dec;

  always_comb begin
    nstate = state;
    load   = 1'b0;
    run    = 1'b0;
    clr    = 1'b0;
    case (state)
      IDLE: begin
        if (io.in_valid) begin
          load   = 1'b1;
          nstate = (io.in_n == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (io.abort) begin
          clr    = 1'b1;
          nstate = IDLE;
        end else begin
          run = 1'b1;
          if (cnt == ONE) nstate = DONE;
        end
      end
      DONE: begin
        if (io.abort) begin
          clr    = 1'b1;
          nstate = IDLE;
        end else if (io.out_ready) begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
    end else if (load) begin
      acc    <= io.in_a;
      cnt    <= io.in_n;
      borrow <= 1'b0;
    end else if (clr) begin
      acc    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
    end else if (run) begin
      acc    <= step_val;
      cnt    <= cnt - ONE;
      borrow <= borrow | at_zero;
    end
  end

  // in_ready is gated by reset so it stays low while rst_n is asserted.
  assign io.in_ready   = rst_n && (state == IDLE);
  assign io.out_valid  = (state == DONE);
  assign io.out_s      = (state == DONE) ? acc : '0;
  assign io.out_borrow = (state == DONE) ? borrow : 1'b0;
  assign io.busy       = (state == RUN) || (state == DONE);
endmodule

// File: tb/tb_alu_iter_decrement.sv
// Bench for alu_iter_decrement: wrap and saturate instances driven in lockstep against a result model.
module tb_alu_iter_decrement;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [3:0] in_a = '0, in_n = '0;
  int         checks = 0, errors = 0;

  alu_iter_decrement_if #(.W(4)) if0 ();
  alu_iter_decrement_if #(.W(4)) if1 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
  assign if0.in_a = in_a;          assign if1.in_a = in_a;
  assign if0.in_n = in_n;          assign if1.in_n = in_n;
  assign if0.abort = abort;        assign if1.abort = abort;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

  alu_iter_decrement #(.W(4), .SATURATE(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .io(if0));
  alu_iter_decrement #(.W(4), .SATURATE(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .io(if1));

  always #5 clk = ~clk;

  // Model: one pending operation, result ready n edges after acceptance.
  logic       m_busy = 1'b0;
  int         m_age = 0;
  logic [3:0] m_a = '0, m_n = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_age  = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1; m_age = 0; m_a = in_a; m_n = in_n;
      end
    end else if (abort) begin
      m_busy = 1'b0;
    end else if (m_age >= int'(m_n) && out_ready) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
  end

  function automatic logic [3:0] exp_s(input logic [3:0] a, input logic [3:0] n, input bit sat);
    int d;
    d = int'(a) - int'(n);
    if (d >= 0) return 4'(d);
    return sat ? 4'd0 : 4'(d);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_port(input string nm, input bit sat, input logic ir, input logic ov,
                            input logic [3:0] s, input logic b, input logic bz);
    logic done;
    done = m_busy && (m_age >= int'(m_n));
    chk({nm, ".in_ready"},   32'(ir), 32'(rst_n && !m_busy));
    chk({nm, ".out_valid"},  32'(ov), 32'(done));
    chk({nm, ".busy"},       32'(bz), 32'(m_busy));
    chk({nm, ".out_s"},      32'(s),  32'(done ? exp_s(m_a, m_n, sat) : 4'd0));
    chk({nm, ".out_borrow"}, 32'(b),  32'(done ? (m_a < m_n) : 1'b0));
  endtask

  always @(negedge clk) begin
    check_port("wrap", 1'b0, if0.in_ready, if0.out_valid, if0.out_s, if0.out_borrow, if0.busy);
    check_port("sat",  1'b1, if1.in_ready, if1.out_valid, if1.out_s, if1.out_borrow, if1.busy);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] n, output int lat,
                        output logic [3:0] s0, output logic b0, output logic [3:0] s1, output logic b1);
    int guard;
    guard = 0;
    while (!if0.in_ready && guard < 50) begin step(); guard++; end
    if (!if0.in_ready) chk("in_ready_wait", 32'd0, 32'd1);
    in_valid = 1'b1; in_a = a; in_n = n;
    step();
    in_valid = 1'b0; in_a = 4'($urandom); in_n = 4'($urandom);
    lat = 0;
    while (!if0.out_valid && lat < 40) begin step(); lat++; end
    if (!if0.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    s0 = if0.out_s; b0 = if0.out_borrow;
    s1 = if1.out_s; b1 = if1.out_borrow;
  endtask

  initial begin
    int lat;
    logic [3:0] s0, s1;
    logic b0, b1;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); abort = 1'($urandom); out_ready = 1'($urandom);
      in_a = 4'($urandom); in_n = 4'($urandom);
      step();
      chk("rst.out_valid", 32'(if0.out_valid), 32'd0);
      chk("rst.in_ready",  32'(if0.in_ready),  32'd0);
      chk("rst.busy",      32'(if1.busy),      32'd0);
      chk("rst.out_s",     32'(if0.out_s),     32'd0);
    end
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    step();
    chk("post_rst.in_ready", 32'(if0.in_ready), 32'd1);

    // Basic.
    run_op(4'b1011, 4'd3, lat, s0, b0, s1, b1);
    chk("basic.lat", 32'(lat), 32'd3);
    chk("basic.s0", 32'(s0), 32'b1000);
    chk("basic.b0", 32'(b0), 32'd0);
    chk("basic.s1", 32'(s1), 32'b1000);
    step();
    chk("basic.in_ready_back", 32'(if0.in_ready), 32'd1);

    // Zero count.
    run_op(4'd5, 4'd0, lat, s0, b0, s1, b1);
    chk("zero.lat", 32'(lat), 32'd0);
    chk("zero.s0", 32'(s0), 32'd5);
    chk("zero.b0", 32'(b0), 32'd0);

    // Underflow.
    run_op(4'd2, 4'd5, lat, s0, b0, s1, b1);
    chk("uf.s0", 32'(s0), 32'b1101);
    chk("uf.b0", 32'(b0), 32'd1);
    chk("uf.s1", 32'(s1), 32'd0);
    chk("uf.b1", 32'(b1), 32'd1);

    // Full-range count.
    run_op(4'd4, 4'd15, lat, s0, b0, s1, b1);
    chk("n15.lat", 32'(lat), 32'd15);
    chk("n15.s0", 32'(s0), 32'd5);
    chk("n15.b0", 32'(b0), 32'd1);
    chk("n15.s1", 32'(s1), 32'd0);
    run_op(4'd15, 4'd15, lat, s0, b0, s1, b1);
    chk("n15max.s0", 32'(s0), 32'd0);
    chk("n15max.b0", 32'(b0), 32'd0);

    // Backpressure.
    step();
    out_ready = 1'b0;
    run_op(4'd9, 4'd2, lat, s0, b0, s1, b1);
    chk("bp.s0", 32'(s0), 32'd7);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 4'd1; in_n = 4'd1;
      step();
      chk("bp.hold_valid", 32'(if0.out_valid), 32'd1);
      chk("bp.hold_s", 32'(if0.out_s), 32'd7);
      chk("bp.in_ready", 32'(if0.in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp.released", 32'(if0.out_valid), 32'd0);
    chk("bp.idle", 32'(if0.in_ready), 32'd1);

    // Abort in the second RUN cycle.
    in_valid = 1'b1; in_a = 4'd12; in_n = 4'd6;
    step();
    in_valid = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort.busy", 32'(if0.busy), 32'd0);
    chk("abort.in_ready", 32'(if0.in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("abort.no_valid", 32'(if0.out_valid | if1.out_valid), 32'd0);
    end

    // Abort ignored in IDLE; same-cycle accept still happens.
    abort = 1'b1; in_valid = 1'b1; in_a = 4'd3; in_n = 4'd1;
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("idle_abort.busy", 32'(if0.busy), 32'd1);
    step();
    chk("idle_abort.valid", 32'(if0.out_valid), 32'd1);
    chk("idle_abort.s", 32'(if0.out_s), 32'd2);
    step();

    // Async reset mid-RUN.
    in_valid = 1'b1; in_a = 4'd8; in_n = 4'd10;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(if0.busy), 32'd0);
    chk("arst.in_ready", 32'(if0.in_ready), 32'd0);
    chk("arst.out_valid", 32'(if0.out_valid), 32'd0);
    chk("arst.out_s", 32'(if1.out_s), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst.recover", 32'(if0.in_ready), 32'd1);
    for (int i = 0; i < 12; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
